// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard control: load-use stall, taken-branch flush, and a countdown
// FSM that holds a multi-cycle multiply in Execute while bubbling Memory.
module pipe_hazard_ctrl #(
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned CW         = $clog2(MUL_CYCLES + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    RA1D,
    input  logic [3:0]    RA2D,
    input  logic [3:0]    WA3E,
    input  logic          MemtoRegE,
    input  logic          BranchTakenE,
    input  logic          MulStartE,
    output logic          StallF,
    output logic          StallD,
    output logic          StallE,
    output logic          FlushD,
    output logic          FlushE,
    output logic          FlushM,
    output logic          MulBusy,
    output logic          MulDone
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          ldstall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        StallF  = 1'b0;
        StallD  = 1'b0;
        StallE  = 1'b0;
        FlushD  = 1'b0;
        FlushE  = 1'b0;
        FlushM  = 1'b0;
        MulBusy = 1'b0;
        MulDone = 1'b0;
        ldstall = MemtoRegE & ((WA3E == RA1D) | (WA3E == RA2D));

        case (state)
            IDLE: begin
                if (BranchTakenE) begin
                    FlushD = 1'b1;
                    FlushE = 1'b1;
                end else if (MulStartE) begin
                    if (MUL_CYCLES == 1) begin
                        MulDone = 1'b1;
                    end else begin
                        StallF  = 1'b1;
                        StallD  = 1'b1;
                        StallE  = 1'b1;
                        FlushM  = 1'b1;
                        cnt_n   = CW'(MUL_CYCLES - 1);
                        state_n = BUSY;
                    end
                end else if (ldstall) begin
                    StallF = 1'b1;
                    StallD = 1'b1;
                    FlushE = 1'b1;
                end
            end
            BUSY: begin
                MulBusy = 1'b1;
                if (cnt > CW'(1)) begin
                    StallF = 1'b1;
                    StallD = 1'b1;
                    StallE = 1'b1;
                    FlushM = 1'b1;
                    cnt_n  = cnt - CW'(1);
                end else begin
                    MulDone = 1'b1;
                    cnt_n   = '0;
                    state_n = IDLE;
                end
            end
        endcase

        // State is already IDLE under reset; only the multiply outputs need masking.
        if (reset) begin
            StallE  = 1'b0;
            FlushM  = 1'b0;
            MulBusy = 1'b0;
            MulDone = 1'b0;
        end
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline control block for the 5-stage ARM-style core. It drives the `en`/`clear` inputs of the Fetch, Decode, Execute and Memory pipeline registers. Stall outputs are inverted to enables; flush outputs go to clears. It resolves load-use hazards and taken branches, and sequences a multi-cycle multiply held in Execute with a countdown FSM.

## Interface
- MUL_CYCLES, 4: Execute-stage occupancy of a multiply, in cycles; must be ≥ 1.
- CW, $clog2(MUL_CYCLES+1): width of the countdown counter.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high; clears state immediately.
- RA1D  in  4  Decode source register 1.
- RA2D  in  4  Decode source register 2.
- WA3E  in  4  Execute destination register.
- MemtoRegE  in  1  Execute instruction is a load.
- BranchTakenE  in  1  taken branch resolved in Execute.
- MulStartE  in  1  Execute instruction is a multiply; held high while that instruction sits in E.
- StallF  out  1  hold the PC register (en = ~StallF).
- StallD  out  1  hold the F/D register.
- StallE  out  1  hold the D/E register.
- FlushD  out  1  clear the F/D register.
- FlushE  out  1  clear the D/E register.
- FlushM  out  1  clear the E/M register (bubble behind the multiply).
- MulBusy  out  1  FSM in BUSY.
- MulDone  out  1  multiply completes this cycle; Execute advances at the next edge.

## Operation
- State: FSM {IDLE, BUSY}, counter cnt[CW-1:0].
- ldstall = MemtoRegE & ((WA3E==RA1D) | (WA3E==RA2D)).
- mulgo = IDLE & MulStartE & ~BranchTakenE.

IDLE:
- If BranchTakenE: FlushD=1 and FlushE=1; all stalls 0; ldstall and MulStartE are ignored; next state IDLE.
- Else if MulStartE with MUL_CYCLES==1: MulDone=1, no stalls, stay IDLE.
- Else if MulStartE with MUL_CYCLES>1: StallF=StallD=StallE=1, FlushM=1; cnt←MUL_CYCLES-1; next state BUSY.
- Else if ldstall: StallF=StallD=1 and FlushE=1; stay IDLE.
- Else: all outputs 0.

BUSY:
- MulBusy=1. BranchTakenE, ldstall and MulStartE are masked.
- If cnt>1: StallF=StallD=StallE=1 and FlushM=1; cnt←cnt-1.
- If cnt==1: MulDone=1, all stalls and flushes 0, cnt←0, next state IDLE.

General rules:
- FlushE and StallE are never both 1.
- FlushE is never asserted in BUSY, so the multiply is never cleared.
- Stall and flush outputs are combinational from state plus inputs; state and cnt are registered.

## Timing
- Reset, asynchronous: state←IDLE, cnt←0 at once, mid-multiply included. The aborted multiply is dropped, with no MulDone.
- Output values during reset: MulBusy=MulDone=0, StallE=FlushM=0. The other outputs follow the IDLE equations on live inputs.
- Multiply at cycle t (mulgo), MUL_CYCLES=N>1:
  - StallE=1 for cycles t..t+N-2.
  - MulDone=1 at cycle t+N-1.
  - The instruction leaves Execute at the edge ending t+N-1, so E occupancy is exactly N cycles.
  - MulBusy=1 for t+1..t+N-1.
- Back-to-back multiplies: a multiply entering E at t+N is accepted with mulgo in IDLE at t+N, giving no dead cycle.
- Load-use stall is one cycle. The next cycle the load is in M, so ldstall drops, and the bubble in E has WA3E from a cleared register (MemtoRegE=0).
- MulStartE together with BranchTakenE in IDLE: the branch wins and no multiply sequence starts.

## Test plan
- Reset mid-BUSY (MUL_CYCLES=4, assert reset in cycle t+2) -> MulBusy=0 immediately, no MulDone; after release, MulStartE=0 gives all outputs 0.
- Load-use: MemtoRegE=1, WA3E=5, RA2D=5 -> StallF=StallD=FlushE=1 for exactly one cycle. With RA1D=RA2D=3 -> no stall.
- Branch: BranchTakenE=1 with ldstall also true -> FlushD=FlushE=1, StallF=StallD=0.
- MUL_CYCLES=4, MulStartE held 4 cycles from t -> StallE=FlushM=1 at t..t+2, MulDone at t+3, MulBusy at t+1..t+3, back in IDLE at t+4.
- Two consecutive multiplies (MulStartE high 8 cycles) -> MulDone at t+3 and t+7, StallE low only at t+3 and t+7.
- MUL_CYCLES=1 build: MulStartE=1 -> MulDone=1 the same cycle, never BUSY, no stalls.
